nabp_angle_sequencer: RTL and testbench
=======================================

// Module: nabp_angle_sequencer
// PURPOSE
//   Host-side angle source directly upstream of the swap control. On a host start pulse it
//   issues a run of projection angles (start, start+STEP, ... modulo ANGLE_MOD), one per
//   request/ack handshake. It also tells the swap control whether further angles remain and
//   reports completion to the host once the final angle has been consumed.
// PARAMETERS
//   ANGLE_W     9    angle width; equals the shared kAngleLength constant
//   ANGLE_MOD   180  angle wrap modulus; must satisfy ANGLE_MOD <= 2**ANGLE_W
//   ANGLE_STEP  1    increment per issued angle; 1 <= ANGLE_STEP < ANGLE_MOD
// PORTS
//   clk                input   1        single clock, all logic on rising edge
//   reset              input   1        synchronous, active-high reset
//   host_start         input   1        1-cycle pulse; latches start_angle and num_angles
//   host_abort         input   1        aborts the run and returns to IDLE
//   host_hold          input   1        while high, pending requests are not acknowledged
//   start_angle        input   ANGLE_W  first angle; sampled on host_start
//   num_angles         input   ANGLE_W  angles in the run, 1..ANGLE_MOD; sampled on host_start
//   host_busy          output  1        high in READY, ACK and DRAIN
//   host_done          output  1        1-cycle pulse when the run completes
//   host_err           output  1        1-cycle pulse when a start is rejected
//   hs_next_angle      input   1        level request from the swap control
//   hs_angle           output  ANGLE_W  current angle; stable from the ack cycle until the next ack
//   hs_next_angle_ack  output  1        1-cycle pulse; hs_angle is valid in this cycle
//   hs_has_next_angle  output  1        high while unacknowledged angles remain
// BEHAVIOUR
//   Reset: state=IDLE. All outputs are 0 in the cycle after reset is sampled, and
//     hs_angle=0. A reset in mid-run discards the run; no done or err pulse is produced.
//   State IDLE: host_start with num_angles in 1..ANGLE_MOD and start_angle < ANGLE_MOD
//     -> READY next cycle: cur=start_angle, rem=num_angles.
//     An invalid start -> host_err=1 for one cycle; the block stays in IDLE.
//     host_start outside IDLE is ignored.
//   State READY: hs_has_next_angle=(rem!=0).
//     If hs_next_angle=1, host_hold=0 and rem!=0 -> ACK.
//     If hs_next_angle=1 and rem==0 -> DONE.
//   State ACK (one cycle):
//     - hs_next_angle_ack=1 and hs_angle=cur in this cycle.
//     - On exit: cur<=wrap(cur+STEP) and rem<=rem-1.
//     - Next state is READY if rem-1!=0, otherwise DRAIN.
//     - Acks are therefore never back-to-back; a request that stays high is serviced
//       again 2 cycles later at the earliest.
//   State DRAIN: hs_has_next_angle=0. The next hs_next_angle=1 -> DONE (no ack is given).
//     host_hold has no effect in DRAIN.
//   State DONE (one cycle): host_done=1 -> IDLE.
//   Latency: request seen in READY -> ack in the following cycle (registered, 1 cycle).
//   hs_has_next_angle is registered and updates in the cycle after the ACK cycle. During
//     the ACK cycle it still reflects rem before the decrement.
//   Wrap: wrap(x) = (x >= ANGLE_MOD) ? x-ANGLE_MOD : x, computed at ANGLE_W+1 bits with
//     no overflow. Example: MOD=180, STEP=1, cur=179 -> 0.
//   num_angles=ANGLE_MOD is legal and gives a full revolution. Angles may repeat only
//     when STEP*num_angles > MOD.
//   Abort: host_abort in any non-IDLE state -> IDLE next cycle. Outputs clear, no done
//     pulse. An abort in the ACK cycle still completes that ack pulse. Abort has priority
//     over a simultaneous request; abort together with host_start in IDLE starts nothing.
//   hs_angle holds its last value in IDLE; it is not cleared on abort.
// STRUCTURE
//   Shared package:
//     - angle_seq_state_t enum {IDLE, READY, ACK, DRAIN, DONE};
//     - ANGLE_W/ANGLE_MOD/ANGLE_STEP defaults, tied to the global kAngleLength
//       configuration value.
//   Sub-module nabp_angle_wrap_counter:
//     - loadable modular accumulator (load, value, en -> wrap(cur+STEP));
//     - also reused by the LUT address generators.
//   This module holds the FSM, the rem down-counter and the handshake outputs.
// TESTING
//   1. Start with start=0, num=3, request held high:
//      acks 2 cycles apart with hs_angle 0,1,2;
//      hs_has_next_angle falls after the third ack;
//      the next request pulses host_done.
//   2. Start with start=178, num=4, STEP=1:
//      angles 178,179,0,1; no value >= 180 ever appears.
//   3. host_hold=1 for 10 cycles while the request is high:
//      no ack during the hold; ack exactly 1 cycle after hold falls.
//   4. Start with num=0, then a start with start_angle=200:
//      host_err pulses each time; state stays IDLE; no ack, no busy.
//   5. host_abort in the ACK cycle and in DRAIN:
//      the ack completes; the block is in IDLE the next cycle; host_done never pulses;
//      a new start works.
//   6. reset asserted mid-run for 1 cycle:
//      all outputs are 0 the next cycle; a subsequent run (start=5, num=2) yields 5,6.

Source files
------------

// File: rtl/nabp_angle_sequencer_pkg.sv
// Shared types and default geometry for the NABP angle sequencer and its helpers.
// Angle width follows the global kAngleLength configuration value.
package nabp_angle_sequencer_pkg;

  localparam int kAngleLength   = 9;
  localparam int ANGLE_W_DEF    = kAngleLength;
  localparam int ANGLE_MOD_DEF  = 180;
  localparam int ANGLE_STEP_DEF = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    ACK   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } angle_seq_state_t;

endpackage

// File: rtl/nabp_angle_wrap_counter.sv
// Loadable modular accumulator: value advances by STEP and wraps at MOD.
// Shared with the LUT address generators.
module nabp_angle_wrap_counter
  import nabp_angle_sequencer_pkg::*;
#(
  parameter int W    = ANGLE_W_DEF,
  parameter int MOD  = ANGLE_MOD_DEF,
  parameter int STEP = ANGLE_STEP_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] value_o
);

  localparam logic [W:0] MOD_EXT  = (W+1)'(MOD);
  localparam logic [W:0] STEP_EXT = (W+1)'(STEP);

  logic [W-1:0] cur_q;
  logic [W-1:0] cur_d;
  logic [W:0]   sum;

  // One extra bit keeps cur+STEP exact before the single conditional subtract.
  always_comb begin
    sum   = {1'b0, cur_q} + STEP_EXT;
    cur_d = cur_q;
    if (load_i) begin
      cur_d = load_val_i;
    end else if (en_i) begin
      cur_d = (sum >= MOD_EXT) ? W'(sum - MOD_EXT) : sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q <= '0;
    end else begin
      cur_q <= cur_d;
    end
  end

  assign value_o = cur_q;

endmodule

// File: rtl/nabp_angle_sequencer.sv
// Host-side angle source feeding the swap control: issues start, start+STEP, ... (mod MOD)
// one angle per request/ack, flags remaining angles and reports completion.
module nabp_angle_sequencer
  import nabp_angle_sequencer_pkg::*;
#(
  parameter int ANGLE_W    = ANGLE_W_DEF,
  parameter int ANGLE_MOD  = ANGLE_MOD_DEF,
  parameter int ANGLE_STEP = ANGLE_STEP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_start,
  input  logic               host_abort,
  input  logic               host_hold,
  input  logic [ANGLE_W-1:0] start_angle,
  input  logic [ANGLE_W-1:0] num_angles,
  output logic               host_busy,
  output logic               host_done,
  output logic               host_err,
  input  logic               hs_next_angle,
  output logic [ANGLE_W-1:0] hs_angle,
  output logic               hs_next_angle_ack,
  output logic               hs_has_next_angle,
  output angle_seq_state_t   dbg_state_o
);

  // Handshake: hs_next_angle is a level request; each accepted request yields exactly one
  // single-cycle hs_next_angle_ack with hs_angle valid in that cycle. The request is not
  // consumed by the ack, so a request left high is served again two cycles later.

  localparam logic [ANGLE_W:0] MOD_EXT = (ANGLE_W+1)'(ANGLE_MOD);

  angle_seq_state_t   state_q, state_d;
  logic [ANGLE_W-1:0] rem_q, rem_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               has_next_q, has_next_d;
  logic               err_q, err_d;
  logic               start_valid;
  logic               load_cur;
  logic [ANGLE_W-1:0] cur_val;

  assign start_valid = (num_angles != '0)
                    && ({1'b0, num_angles} <= MOD_EXT)
                    && ({1'b0, start_angle} < MOD_EXT);

  nabp_angle_wrap_counter #(
    .W    (ANGLE_W),
    .MOD  (ANGLE_MOD),
    .STEP (ANGLE_STEP)
  ) u_cur (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_cur),
    .load_val_i (start_angle),
    .en_i       (state_q == ACK),
    .value_o    (cur_val)
  );

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    angle_d  = angle_q;
    err_d    = 1'b0;
    load_cur = 1'b0;
    case (state_q)
      IDLE: begin
        if (host_start && !host_abort) begin
          if (start_valid) begin
            state_d  = READY;
            rem_d    = num_angles;
            load_cur = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      READY: begin
        if (host_abort) begin
          state_d = IDLE;
        end else if (hs_next_angle) begin
          if (rem_q != '0) begin
            if (!host_hold) begin
              state_d = ACK;
              angle_d = cur_val;
            end
          end else begin
            state_d = DONE;
          end
        end
      end
      ACK: begin
        rem_d = rem_q - ANGLE_W'(1);
        if (host_abort) begin
          state_d = IDLE;
        end else if (rem_q != ANGLE_W'(1)) begin
          state_d = READY;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (host_abort) begin
          state_d = IDLE;
        end else if (hs_next_angle) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered flag: during ACK it still reflects the count before the decrement.
    has_next_d = ((state_d == READY) || (state_d == ACK)) && (rem_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      angle_q    <= '0;
      has_next_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      angle_q    <= angle_d;
      has_next_q <= has_next_d;
      err_q      <= err_d;
    end
  end

  assign host_busy         = (state_q == READY) || (state_q == ACK) || (state_q == DRAIN);
  assign host_done         = (state_q == DONE);
  assign host_err          = err_q;
  assign hs_angle          = angle_q;
  assign hs_next_angle_ack = (state_q == ACK);
  assign hs_has_next_angle = has_next_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_nabp_angle_sequencer.sv
// Self-checking bench for nabp_angle_sequencer: start-validation table, hand-written
// corner sequences and randomized runs scored against an angle-list model.
module tb_nabp_angle_sequencer;
  import nabp_angle_sequencer_pkg::*;

  localparam int W    = 9;
  localparam int MOD  = 180;
  localparam int STEP = 1;

  logic clk = 1'b0;
  logic reset, host_start, host_abort, host_hold, hs_next_angle;
  logic [W-1:0] start_angle, num_angles, hs_angle;
  logic host_busy, host_done, host_err, hs_next_angle_ack, hs_has_next_angle;
  angle_seq_state_t dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int last_angle = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int sa;
    int na;
    bit exp_err;
  } start_vec_t;

  start_vec_t vecs[7];

  nabp_angle_sequencer #(
    .ANGLE_W    (W),
    .ANGLE_MOD  (MOD),
    .ANGLE_STEP (STEP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .host_start        (host_start),
    .host_abort        (host_abort),
    .host_hold         (host_hold),
    .start_angle       (start_angle),
    .num_angles        (num_angles),
    .host_busy         (host_busy),
    .host_done         (host_done),
    .host_err          (host_err),
    .hs_next_angle     (hs_next_angle),
    .hs_angle          (hs_angle),
    .hs_next_angle_ack (hs_next_angle_ack),
    .hs_has_next_angle (hs_has_next_angle),
    .dbg_state_o       (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int sa, input int na);
    start_angle = W'(sa);
    num_angles  = W'(na);
    host_start  = 1'b1;
    tick();
    host_start  = 1'b0;
  endtask

  task automatic abort_now();
    hs_next_angle = 1'b0;
    host_abort    = 1'b1;
    tick();
    host_abort    = 1'b0;
  endtask

  // Model: the run is the list (sa + k*STEP) mod MOD; an angle is handed out one cycle after
  // an un-held request seen while the block is waiting (not acking); with the list empty a
  // request finishes the run.
  task automatic run_model(input int sa, input int na, input bit rnd, input int budget);
    bit active, in_ack, done_seen, req, hold, e_ack, e_done;
    int v;
    exp_q.delete();
    for (int k = 0; k < na; k++) exp_q.push_back(W'((sa + k * STEP) % MOD));
    start_run(sa, na);
    chk("start_busy", host_busy, 1);
    chk("start_has_next", hs_has_next_angle, 1);
    active = 1'b1;
    in_ack = 1'b0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < budget && !done_seen; cyc++) begin
      if (rnd) begin
        req  = ($urandom_range(0, 9) < 7);
        hold = ($urandom_range(0, 9) < 2);
      end else begin
        req  = 1'b1;
        hold = 1'b0;
      end
      hs_next_angle = req;
      host_hold     = hold;
      e_ack  = active && !in_ack && (exp_q.size() > 0) && req && !hold;
      e_done = active && !in_ack && (exp_q.size() == 0) && req;
      tick();
      chk("ack", hs_next_angle_ack, e_ack);
      if (e_ack) begin
        v = exp_q.pop_front();
        chk("angle", hs_angle, v);
        last_angle = v;
      end else begin
        chk("angle_hold", hs_angle, last_angle);
      end
      chk("done", host_done, e_done);
      active = active && !e_done;
      chk("has_next", hs_has_next_angle, e_ack ? 1 : (active && (exp_q.size() > 0)));
      chk("busy", host_busy, active);
      chk("angle_range", hs_angle < MOD, 1);
      in_ack    = e_ack;
      done_seen = e_done;
    end
    if (!done_seen) chk("run_timeout", 0, 1);
    hs_next_angle = 1'b0;
    host_hold     = 1'b0;
    tick();
    chk("done_one_cycle", host_done, 0);
    chk("idle_after_done", dbg_state == IDLE, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vecs[0] = '{sa: 0,   na: 0,   exp_err: 1'b1};
    vecs[1] = '{sa: 200, na: 5,   exp_err: 1'b1};
    vecs[2] = '{sa: 180, na: 1,   exp_err: 1'b1};
    vecs[3] = '{sa: 0,   na: 181, exp_err: 1'b1};
    vecs[4] = '{sa: 179, na: 180, exp_err: 1'b0};
    vecs[5] = '{sa: 5,   na: 1,   exp_err: 1'b0};
    vecs[6] = '{sa: 0,   na: 180, exp_err: 1'b0};

    reset = 1'b1; host_start = 1'b0; host_abort = 1'b0; host_hold = 1'b0;
    hs_next_angle = 1'b0; start_angle = '0; num_angles = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", host_busy, 0);
    chk("rst_done", host_done, 0);
    chk("rst_err", host_err, 0);
    chk("rst_ack", hs_next_angle_ack, 0);
    chk("rst_has_next", hs_has_next_angle, 0);
    chk("rst_angle", hs_angle, 0);
    chk("rst_state_idle", dbg_state == IDLE, 1);

    // Start validation table
    for (int i = 0; i < 7; i++) begin
      start_run(vecs[i].sa, vecs[i].na);
      chk("tbl_err", host_err, vecs[i].exp_err);
      chk("tbl_busy", host_busy, !vecs[i].exp_err);
      chk("tbl_ack", hs_next_angle_ack, 0);
      tick();
      chk("tbl_err_pulse", host_err, 0);
      if (!vecs[i].exp_err) begin
        abort_now();
        chk("tbl_abort_idle", host_busy, 0);
      end
    end

    // Request held high: acks two cycles apart with 0,1,2, then done
    start_run(0, 3);
    hs_next_angle = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      chk("t1_ack", hs_next_angle_ack, (c % 2 == 0) && (c <= 4));
      if ((c % 2 == 0) && (c <= 4)) chk("t1_angle", hs_angle, c / 2);
      chk("t1_has_next", hs_has_next_angle, c <= 4);
      chk("t1_done", host_done, c == 6);
    end
    hs_next_angle = 1'b0;
    tick();
    chk("t1_idle", host_busy, 0);
    last_angle = 2;

    // Wrap across the modulus
    run_model(178, 4, 1'b0, 40);

    // Hold suppresses acks; ack one cycle after hold falls
    start_run(10, 2);
    hs_next_angle = 1'b1;
    host_hold = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_no_ack", hs_next_angle_ack, 0);
    end
    host_hold = 1'b0;
    tick();
    chk("hold_release_ack", hs_next_angle_ack, 1);
    chk("hold_release_angle", hs_angle, 10);
    last_angle = 10;
    abort_now();
    chk("hold_abort_idle", host_busy, 0);

    // Abort in ACK: ack completes, IDLE next cycle, no done
    start_run(20, 3);
    hs_next_angle = 1'b1;
    tick();
    chk("abort_ack_pulse", hs_next_angle_ack, 1);
    chk("abort_ack_angle", hs_angle, 20);
    host_abort = 1'b1;
    tick();
    host_abort = 1'b0;
    hs_next_angle = 1'b0;
    chk("abort_ack_noack", hs_next_angle_ack, 0);
    chk("abort_ack_busy", host_busy, 0);
    chk("abort_ack_has_next", hs_has_next_angle, 0);
    chk("abort_ack_idle", dbg_state == IDLE, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_ack_no_done", host_done, 0);
    end

    // Abort in DRAIN: angle not cleared, no done
    start_run(30, 1);
    hs_next_angle = 1'b1;
    tick();
    chk("drain_ack_angle", hs_angle, 30);
    hs_next_angle = 1'b0;
    tick();
    chk("drain_state", dbg_state == DRAIN, 1);
    chk("drain_has_next", hs_has_next_angle, 0);
    chk("drain_busy", host_busy, 1);
    abort_now();
    chk("drain_abort_busy", host_busy, 0);
    chk("drain_abort_done", host_done, 0);
    chk("drain_abort_angle_kept", hs_angle, 30);
    tick();
    chk("drain_abort_no_done", host_done, 0);
    last_angle = 30;

    // Abort beats a simultaneous request; abort with start in IDLE starts nothing
    start_run(40, 2);
    hs_next_angle = 1'b1;
    host_abort = 1'b1;
    tick();
    chk("abort_req_noack", hs_next_angle_ack, 0);
    chk("abort_req_busy", host_busy, 0);
    hs_next_angle = 1'b0;
    host_start = 1'b1;
    start_angle = W'(1);
    num_angles = W'(1);
    tick();
    host_start = 1'b0;
    host_abort = 1'b0;
    chk("abort_start_busy", host_busy, 0);
    chk("abort_start_err", host_err, 0);
    run_model(40, 2, 1'b0, 40);

    // Reset in mid-run
    start_run(7, 5);
    hs_next_angle = 1'b1;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hs_next_angle = 1'b0;
    chk("midrst_busy", host_busy, 0);
    chk("midrst_done", host_done, 0);
    chk("midrst_err", host_err, 0);
    chk("midrst_ack", hs_next_angle_ack, 0);
    chk("midrst_has_next", hs_has_next_angle, 0);
    chk("midrst_angle", hs_angle, 0);
    chk("midrst_idle", dbg_state == IDLE, 1);
    last_angle = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("midrst_no_done", host_done, 0);
    end
    run_model(5, 2, 1'b0, 40);

    // Full revolution crossing the wrap point
    run_model(90, 180, 1'b0, 400);

    // Randomized runs
    for (int r = 0; r < 25; r++) begin
      run_model($urandom_range(0, MOD - 1), $urandom_range(1, 20), 1'b1, 300);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
